// File: rtl/dimmer_pkg.sv
// Shared constants and step-FSM encoding for the LED dimmer front end.
// The PWM stage imports the same duty width and full-scale value.
package dimmer_pkg;

   localparam int DUTY_W       = 19;
   localparam int DUTY_MAX     = 500_000;
   localparam int STEP         = 50_000;
   localparam int DEBOUNCE_CYC = 1_000_000;
   localparam int HOLD_CYC     = 25_000_000;
   localparam int REPEAT_CYC   = 5_000_000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RPT  = 2'd2
   } step_st_e;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dimmer_ctrl_btn_step.sv
// One push-button channel: 2-FF synchroniser, debounce filter and
// press/hold/auto-repeat FSM producing a registered one-cycle step pulse.
module btn_step #(
   parameter int DEBOUNCE_CYC = dimmer_pkg::DEBOUNCE_CYC,
   parameter int HOLD_CYC     = dimmer_pkg::HOLD_CYC,
   parameter int REPEAT_CYC   = dimmer_pkg::REPEAT_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic step_o
);
   import dimmer_pkg::*;

   localparam int DB_W   = cnt_w(DEBOUNCE_CYC);
   localparam int TM_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int TM_W   = cnt_w(TM_MAX);

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYC - 1);
   localparam logic [TM_W-1:0] RPT_LAST  = TM_W'(REPEAT_CYC - 1);

   logic            sync1_q, sync2_q;
   logic            deb_q, deb_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   step_st_e        st_q, st_d;
   logic [TM_W-1:0] tm_q, tm_d;
   logic            step_q, step_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Counter only advances while the synced level disagrees with the
   // accepted level, so any bounce back restarts the qualification window.
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (db_cnt_q == DB_LAST) begin
            deb_d    = sync2_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q    <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         deb_q    <= deb_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // IDLE is only ever entered with the debounced level low, so seeing it
   // high there is exactly the rising edge.
   always_comb begin
      st_d   = st_q;
      tm_d   = tm_q;
      step_d = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (deb_q) begin
               step_d = 1'b1;
               st_d   = ST_HOLD;
               tm_d   = '0;
            end
         end
         ST_HOLD: begin
            if (!deb_q) begin
               st_d = ST_IDLE;
               tm_d = '0;
            end else if (tm_q == HOLD_LAST) begin
               step_d = 1'b1;
               st_d   = ST_RPT;
               tm_d   = '0;
            end else begin
               tm_d = tm_q + 1'b1;
            end
         end
         ST_RPT: begin
            if (!deb_q) begin
               st_d = ST_IDLE;
               tm_d = '0;
            end else if (tm_q == RPT_LAST) begin
               step_d = 1'b1;
               tm_d   = '0;
            end else begin
               tm_d = tm_q + 1'b1;
            end
         end
         default: begin
            st_d = ST_IDLE;
            tm_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_IDLE;
         tm_q   <= '0;
         step_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         tm_q   <= tm_d;
         step_q <= step_d;
      end
   end

   assign step_o = step_q;

endmodule

// File: rtl/dimmer_ctrl.sv
// Dimmer front end: two debounced buttons drive a saturating duty-compare
// word for the PWM stage, with registered full/empty flags.
module dimmer_ctrl #(
   parameter int DUTY_W       = dimmer_pkg::DUTY_W,
   parameter int DUTY_MAX     = dimmer_pkg::DUTY_MAX,
   parameter int STEP         = dimmer_pkg::STEP,
   parameter int DEBOUNCE_CYC = dimmer_pkg::DEBOUNCE_CYC,
   parameter int HOLD_CYC     = dimmer_pkg::HOLD_CYC,
   parameter int REPEAT_CYC   = dimmer_pkg::REPEAT_CYC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn_up,
   input  logic              btn_down,
   output logic [DUTY_W-1:0] duty,
   output logic              at_max,
   output logic              at_min
);
   import dimmer_pkg::*;

   localparam logic [DUTY_W:0]   MAX_X  = (DUTY_W + 1)'(DUTY_MAX);
   localparam logic [DUTY_W:0]   STEP_X = (DUTY_W + 1)'(STEP);
   localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);

   logic              up_step, dn_step;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              at_max_q, at_max_d;
   logic              at_min_q, at_min_d;
   logic [DUTY_W:0]   duty_x, sum_x, diff_x;

   btn_step #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
   ) u_up (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_up),
      .step_o (up_step)
   );

   btn_step #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
   ) u_dn (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_down),
      .step_o (dn_step)
   );

   // One extra bit on every compare and add so nothing can wrap.
   assign duty_x = {1'b0, duty_q};
   assign sum_x  = duty_x + STEP_X;
   assign diff_x = duty_x - STEP_X;

   always_comb begin
      duty_d = duty_q;
      if (up_step && !dn_step) begin
         if (duty_x > (MAX_X - STEP_X)) duty_d = MAX_V;
         else                           duty_d = sum_x[DUTY_W-1:0];
      end else if (dn_step && !up_step) begin
         if (duty_x < STEP_X) duty_d = '0;
         else                 duty_d = diff_x[DUTY_W-1:0];
      end
      at_max_d = (duty_d == MAX_V);
      at_min_d = (duty_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q   <= '0;
         at_max_q <= 1'b0;
         at_min_q <= 1'b1;
      end else begin
         duty_q   <= duty_d;
         at_max_q <= at_max_d;
         at_min_q <= at_min_d;
      end
   end

   assign duty   = duty_q;
   assign at_max = at_max_q;
   assign at_min = at_min_q;

endmodule

// File: tb/tb_dimmer_ctrl.sv
// Directed bench for dimmer_ctrl with shortened timing constants.
module tb_dimmer_ctrl;

   localparam int DW = 19;

   logic          clk, rst_n;
   logic          btn_up, btn_down, up2, down2;
   logic [DW-1:0] duty, duty2;
   logic          at_max, at_min, at_max2, at_min2;

   int vec_cnt = 0;
   int err_cnt = 0;

   dimmer_ctrl #(
      .DUTY_W(DW), .DUTY_MAX(500), .STEP(100),
      .DEBOUNCE_CYC(8), .HOLD_CYC(40), .REPEAT_CYC(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
      .duty(duty), .at_max(at_max), .at_min(at_min)
   );

   // Second instance with a full scale that is not a multiple of STEP,
   // so the floor clamp from a partial step can be reached.
   dimmer_ctrl #(
      .DUTY_W(DW), .DUTY_MAX(450), .STEP(100),
      .DEBOUNCE_CYC(8), .HOLD_CYC(40), .REPEAT_CYC(10)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .btn_up(up2), .btn_down(down2),
      .duty(duty2), .at_max(at_max2), .at_min(at_min2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      btn_up = 0; btn_down = 0; up2 = 0; down2 = 0;
      rst_n = 0;
      tick(2);
      rst_n = 1;
   endtask

   // Number of step events seen t cycles after a press held throughout.
   function automatic int steps_at(input int t);
      return int'(t >= 12) + int'(t >= 52) + int'(t >= 62) + int'(t >= 72) + int'(t >= 82)
           + ((t >= 92) ? ((t - 92) / 10 + 1) : 0);
   endfunction

   task automatic test_reset();
      #3 rst_n = 0;
      #1;
      vec_cnt++;
      if (duty !== 0 || at_min !== 1'b1 || at_max !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset: duty=%0d at_min=%b at_max=%b, want 0/1/0", duty, at_min, at_max);
      end
      vec_cnt++;
      if (duty2 !== 0 || at_min2 !== 1'b1) begin
         err_cnt++;
         $display("FAIL reset2: duty=%0d at_min=%b, want 0/1", duty2, at_min2);
      end
      tick(2);
      rst_n = 1;
   endtask

   task automatic test_clean_press();
      int exp;
      do_reset();
      btn_up = 1;
      for (int t = 1; t <= 40; t++) begin
         tick(1);
         exp = (t >= 12) ? 100 : 0;
         vec_cnt++;
         if (duty !== DW'(exp)) begin
            err_cnt++;
            $display("FAIL clean_press t=%0d: duty=%0d want %0d", t, duty, exp);
         end
         if (t == 20) btn_up = 0;
      end
   endtask

   task automatic test_bouncy();
      do_reset();
      for (int t = 0; t < 60; t++) begin
         btn_up = (t < 30) && ((t % 5) < 3);
         tick(1);
         vec_cnt++;
         if (duty !== 0 || at_min !== 1'b1) begin
            err_cnt++;
            $display("FAIL bouncy t=%0d: duty=%0d at_min=%b want 0/1", t, duty, at_min);
         end
      end
      btn_up = 0;
   endtask

   task automatic test_hold_repeat();
      int exp;
      do_reset();
      btn_up = 1;
      for (int t = 1; t <= 200; t++) begin
         tick(1);
         exp = steps_at(t) * 100;
         if (exp > 500) exp = 500;
         vec_cnt++;
         if (duty !== DW'(exp) || at_max !== (exp == 500)) begin
            err_cnt++;
            $display("FAIL hold_repeat t=%0d: duty=%0d at_max=%b want %0d/%b",
                     t, duty, at_max, exp, exp == 500);
         end
      end
      btn_up = 0;
      tick(20);
   endtask

   task automatic test_both_and_floor();
      int exp;
      do_reset();
      btn_up = 1;
      tick(90);
      btn_up = 0;
      tick(20);
      vec_cnt++;
      if (duty !== 500 || at_max !== 1'b1) begin
         err_cnt++;
         $display("FAIL both_setup: duty=%0d at_max=%b want 500/1", duty, at_max);
      end
      btn_up = 1; btn_down = 1;
      for (int t = 1; t <= 40; t++) begin
         tick(1);
         vec_cnt++;
         if (duty !== 500) begin
            err_cnt++;
            $display("FAIL both_cancel t=%0d: duty=%0d want 500", t, duty);
         end
         if (t == 20) begin btn_up = 0; btn_down = 0; end
      end
      btn_down = 1;
      for (int t = 1; t <= 30; t++) begin
         tick(1);
         exp = (t >= 12) ? 400 : 500;
         vec_cnt++;
         if (duty !== DW'(exp) || at_max !== (exp == 500)) begin
            err_cnt++;
            $display("FAIL down_after_max t=%0d: duty=%0d at_max=%b want %0d", t, duty, at_max, exp);
         end
         if (t == 20) btn_down = 0;
      end
      tick(20);
      // dut2: climb to 450, then hold down through 350,250,150,50 and clamp to 0.
      up2 = 1;
      tick(90);
      up2 = 0;
      tick(20);
      vec_cnt++;
      if (duty2 !== 450 || at_max2 !== 1'b1) begin
         err_cnt++;
         $display("FAIL floor_setup: duty=%0d at_max=%b want 450/1", duty2, at_max2);
      end
      down2 = 1;
      for (int t = 1; t <= 120; t++) begin
         tick(1);
         exp = (steps_at(t) == 0) ? 450 : 450 - 100 * steps_at(t);
         if (exp < 0) exp = 0;
         vec_cnt++;
         if (duty2 !== DW'(exp) || at_min2 !== (exp == 0)) begin
            err_cnt++;
            $display("FAIL floor t=%0d: duty=%0d at_min=%b want %0d/%b", t, duty2, at_min2, exp, exp == 0);
         end
      end
      down2 = 0;
      tick(20);
   endtask

   task automatic test_reset_midop();
      int exp;
      do_reset();
      btn_up = 1;
      tick(64);
      vec_cnt++;
      if (duty !== 300) begin
         err_cnt++;
         $display("FAIL midop_setup: duty=%0d want 300", duty);
      end
      #2 rst_n = 0;
      #1;
      vec_cnt++;
      if (duty !== 0 || at_min !== 1'b1 || at_max !== 1'b0) begin
         err_cnt++;
         $display("FAIL midop_reset: duty=%0d at_min=%b at_max=%b want 0/1/0", duty, at_min, at_max);
      end
      tick(1);
      rst_n = 1;
      for (int t = 1; t <= 20; t++) begin
         tick(1);
         exp = (t >= 12) ? 100 : 0;
         vec_cnt++;
         if (duty !== DW'(exp)) begin
            err_cnt++;
            $display("FAIL midop_repress t=%0d: duty=%0d want %0d", t, duty, exp);
         end
      end
      btn_up = 0;
      tick(20);
   endtask

   initial begin
      rst_n = 1; btn_up = 0; btn_down = 0; up2 = 0; down2 = 0;
      test_reset();
      test_clean_press();
      test_bouncy();
      test_hold_repeat();
      test_both_and_floor();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
